inverse_result_stream: RTL
==========================

Name: inverse_result_stream

Overview:
Reader end of the inverse datapath result interface. It accepts the finished N×N inverse matrix from the datapath one full row per handshake and buffers all N rows locally. It then serialises the elements row-major to the host side over a valid/ready stream. It sits between the inverse datapath output and the host bus adapter, and obeys the same global `en` stall as the datapath and its counter.

Parameters:
- N, 8, matrix dimension (rows = columns); legal range 2..16.
- WIDTH, 27, element width in bits (matches the 27-bit mult/div/sqrt units).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; when low, no handshake completes and no state changes.
- flush  in  1  synchronous abort to IDLE; highest priority after rst.
- cap_valid  in  1  datapath presents a result row.
- cap_ready  out  1  block can accept a row.
- cap_row  in  N*WIDTH  row data; element c is at bits [c*WIDTH +: WIDTH].
- out_valid  out  1  out_data holds a valid element.
- out_ready  in  1  host accepts the element.
- out_data  out  WIDTH  current element, row-major order.
- out_last  out  1  high with element (N-1,N-1).
- done  out  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Reset (async): state=IDLE, row_cnt=0, elem_idx=0, done=0, buffer contents don't-care.
- Outputs while rst is asserted: cap_ready=0, out_valid=0, out_last=0, out_data=0.
- States: IDLE, CAPTURE, STREAM.
- cap_ready = en && !rst && (state==IDLE || state==CAPTURE); combinational from registered state.
- out_valid = en && state==STREAM.
- out_data = buf[elem_idx], driven from registers; 0 whenever state!=STREAM.
- out_last = out_valid && elem_idx==N*N-1.
- Capture handshake = cap_valid && cap_ready; writes row row_cnt.
- IDLE: on a capture handshake, write row 0, row_cnt<=1, go to CAPTURE.
- CAPTURE: each handshake writes row row_cnt. If row_cnt==N-1, row_cnt<=0, elem_idx<=0, go to STREAM; otherwise row_cnt<=row_cnt+1. A gap in cap_valid simply holds state.
- STREAM: output handshake = out_valid && out_ready; each one increments elem_idx. The handshake with out_last high sets elem_idx<=0, state<=IDLE, and done<=1 on the next edge. done self-clears after one cycle.
- Latency: first element is valid the cycle after the Nth row handshake (given en=1). Best case is N + N*N cycles from first row to last element.
- cap_valid during STREAM is ignored: cap_ready=0, buffer is not written.
- en low mid-transfer: all counters and state freeze; out_valid and cap_ready drop. Resuming resumes at the same elem_idx and row_cnt with no loss or duplication.
- out_ready held low: out_data and elem_idx hold indefinitely.
- flush (with en high or low): state<=IDLE, row_cnt<=0, elem_idx<=0, done<=0. A handshake in the same cycle is discarded. done is not pulsed.
- Async rst mid-STREAM: out_valid drops immediately (combinational from rst), and the block restarts in IDLE.
- Back-to-back operation: a new capture may handshake in the cycle after done asserts, because the state is already IDLE.
- Data is passed bit-exact, with no arithmetic or sign handling. Index widths are $clog2(N) for row_cnt and $clog2(N*N) for elem_idx; elem_idx never wraps past N*N-1.

Decomposition:
- Shared package `inverse_pkg`:
  - enum `stream_state_t` {IDLE, CAPTURE, STREAM};
  - localparam `INV_WIDTH` = 27;
  - localparam `INV_N` = 8.
- Natural sub-module `result_buf`: an N-row × N*WIDTH register file with a one-row write port and a one-element combinational read port (row = elem_idx/N, col = elem_idx%N).
- The FSM and counters stay in the top module.
- Interface bundle `ifc_inverse_result_stream` carries clk plus all ports, with modports for the DUT and the testbench.

Test Plan:
- Basic transfer (N=8): element (r,c) = r*16+c, 8 rows back-to-back with cap_valid=1, out_ready=1.
  - Response: 64 elements out in order 0,1..7,16..23,..,119.
  - out_last only on 119; done pulses exactly once, one cycle after the 119 handshake.
- Gapped capture plus host backpressure: rows 2 and 5 are delayed 3 cycles each, and out_ready toggles 1,0,0,1.
  - Response: same 64-value sequence, no duplicates.
  - out_data is stable while out_ready=0.
- en stall: drop en for 5 cycles after row 3 is captured, and again after element 20 is accepted.
  - Response: cap_ready=0 and out_valid=0 during both stalls.
  - Stream resumes with element 21 (value 37); total 64 elements.
- Ignored capture: drive cap_valid=1 with all-ones rows throughout STREAM.
  - Response: cap_ready=0 throughout; output still equals the original matrix.
- flush mid-stream at element 10, then capture a new matrix with values +1000.
  - Response: no done pulse for the aborted transfer; new stream starts at 1000; elem_idx restarted.
- Async rst asserted between clock edges during CAPTURE row 4.
  - Response: out_valid, cap_ready and done are 0 immediately.
  - After release, the block is in IDLE and accepts row 0 of a fresh matrix.

Source files
------------

// File: rtl/inverse_pkg.sv
// Shared definitions for the inverse datapath result path.
//   stream_state_t : FSM states of the result reader
//   INV_WIDTH      : element width of the mult/div/sqrt units
//   INV_N          : default matrix dimension
package inverse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STREAM  = 2'd2
  } stream_state_t;

  localparam int INV_WIDTH = 27;
  localparam int INV_N     = 8;

endpackage

// File: rtl/ifc_inverse_result_stream.sv
// Signal bundle for inverse_result_stream.
//   clk                               : system clock (interface port)
//   rst, en, flush                    : reset / global enable / abort
//   cap_valid, cap_ready, cap_row     : row capture handshake from datapath
//   out_valid, out_ready, out_data,
//   out_last, done                    : element stream towards the host
// Modports: dut (block side) and tb (driver/monitor side).
interface ifc_inverse_result_stream
  import inverse_pkg::*;
#(
  parameter int N     = INV_N,
  parameter int WIDTH = INV_WIDTH
) (
  input logic clk
);

  logic               rst;
  logic               en;
  logic               flush;
  logic               cap_valid;
  logic               cap_ready;
  logic [N*WIDTH-1:0] cap_row;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic               done;

  modport dut (
    input  clk, rst, en, flush, cap_valid, cap_row, out_ready,
    output cap_ready, out_valid, out_data, out_last, done
  );

  modport tb (
    input  clk, cap_ready, out_valid, out_data, out_last, done,
    output rst, en, flush, cap_valid, cap_row, out_ready
  );

endinterface

// File: rtl/inverse_result_stream_result_buf.sv
// result_buf: N-row x N*WIDTH register file holding the captured inverse.
//   clk     : system clock
//   wr_en   : write a whole row this cycle
//   wr_row  : row address of the write
//   wr_data : row data, element c at bits [c*WIDTH +: WIDTH]
//   rd_idx  : row-major element index (row = idx/N, col = idx%N)
//   rd_data : selected element, combinational from the stored rows
// Contents are not reset; they are always fully rewritten before being read.
module result_buf
  import inverse_pkg::*;
#(
  parameter int N     = INV_N,
  parameter int WIDTH = INV_WIDTH,
  parameter int RW    = $clog2(N),
  parameter int EW    = $clog2(N*N)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [RW-1:0]      wr_row,
  input  logic [N*WIDTH-1:0] wr_data,
  input  logic [EW-1:0]      rd_idx,
  output logic [WIDTH-1:0]   rd_data
);

  logic [N*WIDTH-1:0] rows [N];
  logic [WIDTH-1:0]   rd_elems [N];
  logic [RW-1:0]      rd_row;
  logic [RW-1:0]      rd_col;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      rows[wr_row] <= wr_data;
    end
  end

  // rd_idx < N*N, so both quotient and remainder fit in RW bits.
  assign rd_row = RW'(rd_idx / EW'(N));
  assign rd_col = RW'(rd_idx % EW'(N));

  // Unpack the addressed row into elements, then pick the column.
  for (genvar gi = 0; gi < N; gi++) begin : g_col
    assign rd_elems[gi] = rows[rd_row][gi*WIDTH +: WIDTH];
  end

  assign rd_data = rd_elems[rd_col];

endmodule

// File: rtl/inverse_result_stream.sv
// inverse_result_stream: captures an N x N inverse one row per handshake,
// then replays it row-major, one element per handshake, towards the host.
//   clk, rst   : clock / asynchronous active-high reset
//   en         : global stall; when low nothing handshakes and nothing moves
//   flush      : synchronous abort back to IDLE
//   cap_valid/cap_ready/cap_row : row input from the datapath
//   out_valid/out_ready/out_data/out_last : element stream to the host
//   done       : one-cycle pulse after the final element is accepted
module inverse_result_stream
  import inverse_pkg::*;
#(
  parameter int N     = INV_N,
  parameter int WIDTH = INV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush,
  input  logic               cap_valid,
  output logic               cap_ready,
  input  logic [N*WIDTH-1:0] cap_row,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic               done
);

  localparam int RW = $clog2(N);
  localparam int EW = $clog2(N*N);
  localparam logic [RW-1:0] ROW_LAST  = RW'(N-1);
  localparam logic [EW-1:0] ELEM_LAST = EW'(N*N-1);

  stream_state_t   state_reg, state_next;
  logic [RW-1:0]   row_cnt_reg, row_cnt_next;
  logic [EW-1:0]   elem_idx_reg, elem_idx_next;
  logic            done_reg, done_next;

  logic            cap_hs;
  logic            out_hs;
  logic            buf_we;
  logic [WIDTH-1:0] buf_rd;

  assign cap_hs = cap_valid && cap_ready;
  assign out_hs = out_valid && out_ready;
  // A row arriving in the same cycle as flush belongs to the aborted transfer.
  assign buf_we = cap_hs && !flush;

  result_buf #(
    .N     (N),
    .WIDTH (WIDTH),
    .RW    (RW),
    .EW    (EW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_row  (row_cnt_reg),
    .wr_data (cap_row),
    .rd_idx  (elem_idx_reg),
    .rd_data (buf_rd)
  );

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      row_cnt_reg  <= '0;
      elem_idx_reg <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      row_cnt_reg  <= row_cnt_next;
      elem_idx_reg <= elem_idx_next;
      done_reg     <= done_next;
    end
  end

  // Next-state logic. cap_hs/out_hs already include en, so a stalled cycle
  // simply holds everything; done is a pulse and always self-clears.
  always_comb begin
    state_next    = state_reg;
    row_cnt_next  = row_cnt_reg;
    elem_idx_next = elem_idx_reg;
    done_next     = 1'b0;
    if (flush) begin
      state_next    = IDLE;
      row_cnt_next  = '0;
      elem_idx_next = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (cap_hs) begin
            row_cnt_next = RW'(1);
            state_next   = CAPTURE;
          end
        end
        CAPTURE: begin
          if (cap_hs) begin
            if (row_cnt_reg == ROW_LAST) begin
              row_cnt_next  = '0;
              elem_idx_next = '0;
              state_next    = STREAM;
            end else begin
              row_cnt_next = row_cnt_reg + RW'(1);
            end
          end
        end
        STREAM: begin
          if (out_hs) begin
            if (elem_idx_reg == ELEM_LAST) begin
              elem_idx_next = '0;
              state_next    = IDLE;
              done_next     = 1'b1;
            end else begin
              elem_idx_next = elem_idx_reg + EW'(1);
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Outputs. The async reset forces state_reg to IDLE immediately, so
  // out_valid and out_data fall with rst; cap_ready also sees rst directly.
  always_comb begin
    cap_ready = en && !rst && (state_reg == IDLE || state_reg == CAPTURE);
    out_valid = en && (state_reg == STREAM);
    out_data  = (state_reg == STREAM) ? buf_rd : '0;
    out_last  = out_valid && (elem_idx_reg == ELEM_LAST);
    done      = done_reg;
  end

endmodule
